// File: rtl/cube_table_seq.sv
// cube_table_seq: fills mem[BASE_ADDR .. BASE_ADDR+COUNT-1] with n^3 mod 2^DW.
// Each cube is built by repeated addition. SQ adds n to itself n times to form n*n.
// CUBE then adds n*n to itself n times to form n^3.
// Each result is written through an arbitrated write port, using a req/gnt handshake.
module cube_table_seq #(
   parameter int DW        = 8,
   parameter int AW        = 8,
   parameter int BASE_ADDR = 20,
   parameter int COUNT     = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          mem_req,
   input  logic          mem_gnt,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQ,
      S_CUBE,
      S_WR,
      S_DONE
   } state_t;

   // Index of the final table entry; COUNT may be as large as 2^DW.
   localparam logic [DW-1:0] LAST = DW'(COUNT - 1);

   state_t        state_q, state_d;
   logic [DW-1:0] n_q,     n_d;
   logic [DW-1:0] cnt_q,   cnt_d;
   logic [DW-1:0] sq_q,    sq_d;
   logic [DW-1:0] acc_q,   acc_d;
   logic [AW-1:0] addr_q,  addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;
   logic          req_q,   req_d;

   // Next-state logic; the registered outputs are decoded from the state being entered.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      sq_d    = sq_q;
      acc_d   = acc_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SQ;
               n_d     = '0;
               cnt_d   = '0;
               sq_d    = '0;
            end
         end
         S_SQ: begin
            if (cnt_q == n_q) begin
               state_d = S_CUBE;
               cnt_d   = '0;
               acc_d   = '0;
            end else begin
               sq_d  = sq_q + n_q;
               cnt_d = cnt_q + DW'(1);
            end
         end
         S_CUBE: begin
            if (cnt_q == n_q) begin
               state_d = S_WR;
               addr_d  = AW'(BASE_ADDR) + AW'(n_q);
               wdata_d = acc_q;
            end else begin
               acc_d = acc_q + sq_q;
               cnt_d = cnt_q + DW'(1);
            end
         end
         S_WR: begin
            // addr/wdata stay frozen until the arbiter grants the write
            if (mem_gnt) begin
               if (n_q == LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SQ;
                  n_d     = n_q + DW'(1);
                  cnt_d   = '0;
                  sq_d    = '0;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      req_d  = (state_d == S_WR);
   end

   // State, datapath and output registers; reset aborts a fill immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         cnt_q   <= '0;
         sq_q    <= '0;
         acc_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         sq_q    <= sq_d;
         acc_q   <= acc_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         req_q   <= req_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_req   = req_q;
   assign mem_we    = req_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_cube_table_seq.sv
// Bench for cube_table_seq. The reference model tracks a fill by phase only:
// idle, computing, writing or done. Entry n spends 2n+2 compute cycles before its
// write cycle. The model compares every DUT output on every cycle.
module tb_cube_table_seq;

   localparam int BASE = 20;
   localparam int CNT  = 11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       mem_gnt = 1'b0;
   logic       busy, done, mem_req, mem_we;
   logic [7:0] mem_addr, mem_wdata;

   logic       start2 = 1'b0;
   logic       gnt2 = 1'b1;
   logic       busy2, done2, req2, we2;
   logic [7:0] addr2, data2;

   always #5 clk = ~clk;

   cube_table_seq #(.DW(8), .AW(8), .BASE_ADDR(BASE), .COUNT(CNT)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata)
   );

   cube_table_seq #(.DW(8), .AW(8), .BASE_ADDR(255), .COUNT(1)) u_one (
      .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
      .mem_req(req2), .mem_gnt(gnt2), .mem_we(we2),
      .mem_addr(addr2), .mem_wdata(data2)
   );

   typedef enum int {M_IDLE, M_CALC, M_WR, M_DONE} mph_t;

   int   n_chk = 0;
   int   n_pass = 0;
   mph_t m_ph = M_IDLE;
   int   m_n = 0;
   int   m_left = 0;
   int   cyc = 0;
   int   dones = 0;
   int   stalls = 0;
   int   wr_addr[$];
   int   wr_data[$];
   int   done_cyc[$];
   int   LIT[11] = '{0, 1, 8, 27, 64, 125, 216, 87, 0, 217, 232};

   function automatic int cube8(input int n);
      return (n * n * n) & 255;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Compare all outputs against what the model phase demands.
   task automatic check_outputs();
      int e_busy, e_done, e_req;
      e_busy = (m_ph != M_IDLE);
      e_done = (m_ph == M_DONE);
      e_req  = (m_ph == M_WR);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("mem_req", mem_req, e_req);
      chk("mem_we", mem_we, e_req);
      if (m_ph == M_WR) begin
         chk("mem_addr", mem_addr, (BASE + m_n) & 255);
         chk("mem_wdata", mem_wdata, cube8(m_n));
      end
   endtask

   task automatic obs();
      @(negedge clk);
      cyc++;
      check_outputs();
      if (done) begin
         dones++;
         done_cyc.push_back(cyc);
      end
   endtask

   // Drive inputs for the next rising edge and move the model accordingly.
   task automatic advance(input logic st, input logic g);
      start   = st;
      mem_gnt = g;
      if (mem_req && g) begin
         wr_addr.push_back(int'(mem_addr));
         wr_data.push_back(int'(mem_wdata));
      end
      case (m_ph)
         M_IDLE: if (st) begin
            m_ph = M_CALC; m_n = 0; m_left = 2; cyc = 0;
         end
         M_CALC: begin
            m_left--;
            if (m_left == 0) m_ph = M_WR;
         end
         M_WR: if (g) begin
            if (m_n == CNT - 1) m_ph = M_DONE;
            else begin
               m_n++; m_left = 2 * m_n + 2; m_ph = M_CALC;
            end
         end
         default: m_ph = M_IDLE;
      endcase
   endtask

   task automatic begin_fill();
      wr_addr.delete();
      wr_data.delete();
      done_cyc.delete();
      dones  = 0;
      stalls = 0;
      obs();
      advance(1'b1, 1'b1);
   endtask

   // mode 0: gnt=1; 1: stall 5 at n=3; 2: stray starts; 3: random; 4: start held
   task automatic run(input int mode, input int ndone, input int maxc);
      logic st, g;
      for (int k = 0; k < maxc; k++) begin
         obs();
         st = 1'b0;
         g  = 1'b1;
         case (mode)
            1: if (m_ph == M_WR && m_n == 3 && stalls < 5) begin g = 1'b0; stalls++; end
            2: st = (cyc == 10 || cyc == 50);
            3: begin
               st = ($urandom_range(0, 7) == 0);
               g  = ($urandom_range(0, 3) != 0);
               if (m_ph == M_WR && !g) stalls++;
            end
            4: st = 1'b1;
            default: ;
         endcase
         advance(st, g);
         if (dones >= ndone) return;
      end
      chk("timeout_dones", dones, ndone);
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         obs();
         advance(1'b0, 1'b1);
      end
   endtask

   task automatic check_table(input string tag, input int off);
      for (int i = 0; i < CNT; i++) begin
         chk({tag, "_addr"}, wr_addr[off + i], BASE + i);
         chk({tag, "_data"}, wr_data[off + i], LIT[i]);
      end
   endtask

   initial begin
      int w1, wc, wa, wd, d1, dc, b5;
      // reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_busy2", busy2, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycles(3);

      // 1: plain fill
      begin_fill();
      run(0, 1, 400);
      chk("t1_writes", wr_addr.size(), CNT);
      if (wr_addr.size() == CNT) check_table("t1", 0);
      chk("t1_dones", dones, 1);
      if (done_cyc.size() > 0) chk("t1_done_cyc", done_cyc[0], 144);
      obs();
      chk("t1_busy_after", busy, 0);
      advance(1'b0, 1'b1);
      idle_cycles(3);

      // 2: five grant-low cycles at the n=3 write
      begin_fill();
      run(1, 1, 400);
      chk("t2_writes", wr_addr.size(), CNT);
      if (wr_addr.size() == CNT) check_table("t2", 0);
      if (done_cyc.size() > 0) chk("t2_done_cyc", done_cyc[0], 149);
      idle_cycles(3);

      // 3: start pulses while busy are ignored
      begin_fill();
      run(2, 1, 400);
      idle_cycles(200);
      chk("t3_writes", wr_addr.size(), CNT);
      chk("t3_dones", dones, 1);
      if (done_cyc.size() > 0) chk("t3_done_cyc", done_cyc[0], 144);

      // 4: reset in the middle of n=5 squaring
      begin_fill();
      for (int k = 0; k < 400; k++) begin
         obs();
         if (m_ph == M_CALC && m_n == 5 && m_left >= 9) break;
         advance(1'b0, 1'b1);
      end
      chk("t4_reached_n5", m_n, 5);
      rst_n = 1'b0;
      m_ph  = M_IDLE;
      start = 1'b0;
      #1;
      chk("t4_busy0", busy, 0);
      chk("t4_req0", mem_req, 0);
      chk("t4_we0", mem_we, 0);
      chk("t4_addr0", mem_addr, 0);
      chk("t4_data0", mem_wdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycles(20);
      chk("t4_writes_before", wr_addr.size(), 5);
      begin_fill();
      run(0, 1, 400);
      chk("t4_refill_writes", wr_addr.size(), CNT);
      if (wr_addr.size() == CNT) check_table("t4", 0);
      idle_cycles(3);

      // 5: start held high restarts after DONE
      begin_fill();
      run(4, 2, 800);
      idle_cycles(5);
      chk("t5_dones", dones, 2);
      chk("t5_writes", wr_addr.size(), 2 * CNT);
      if (wr_addr.size() == 2 * CNT) check_table("t5_second", CNT);
      if (done_cyc.size() == 2) chk("t5_second_done_cyc", done_cyc[1], 144);

      // random grants and stray starts
      for (int r = 0; r < 4; r++) begin
         begin_fill();
         run(3, 1, 2000);
         chk("rnd_writes", wr_addr.size(), CNT);
         chk("rnd_dones", dones, 1);
         if (done_cyc.size() > 0) chk("rnd_done_cyc", done_cyc[0], 144 + stalls);
         for (int i = 0; i < wr_data.size(); i++) chk("rnd_data", wr_data[i], cube8(i));
         idle_cycles(2);
      end

      // 6: COUNT=1 at BASE_ADDR=255
      w1 = 0; wc = 0; wa = -1; wd = -1; d1 = 0; dc = 0; b5 = -1;
      @(negedge clk);
      start2 = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (done2) begin d1++; dc = c; end
         if (req2 && gnt2) begin w1++; wc = c; wa = addr2; wd = data2; end
         if (c == 5) b5 = busy2;
      end
      chk("t6_writes", w1, 1);
      chk("t6_write_cyc", wc, 3);
      chk("t6_addr", wa, 255);
      chk("t6_data", wd, 0);
      chk("t6_dones", d1, 1);
      chk("t6_done_cyc", dc, 4);
      chk("t6_busy_after", b5, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
